// File: rtl/ttc_broadcast_transmitter_if.sv
`default_nettype none
// ============================================================================
// Module   : ttc_broadcast_transmitter_if
// Brief    : Request/broadcast bundle between a TTC request source and the
//            broadcast transmitter.
// Revision : 1.0 - initial release
// ============================================================================
interface ttc_broadcast_transmitter_if;
  logic        tx_enable;
  logic        req_bcnt_reset;
  logic        req_evt_reset;
  logic        req_ts_reset;
  logic        req_async_start;
  logic        req_async_stop;
  logic        req_fill_type;
  logic [4:0]  fill_type_in;
  logic [7:0]  brcst;
  logic        brcst_str;
  logic        busy;
  logic [31:0] sent_count;
  logic [31:0] dropped_count;

  modport master (
    output tx_enable, req_bcnt_reset, req_evt_reset, req_ts_reset,
           req_async_start, req_async_stop, req_fill_type, fill_type_in,
    input  brcst, brcst_str, busy, sent_count, dropped_count
  );

  modport slave (
    input  tx_enable, req_bcnt_reset, req_evt_reset, req_ts_reset,
           req_async_start, req_async_stop, req_fill_type, fill_type_in,
    output brcst, brcst_str, busy, sent_count, dropped_count
  );
endinterface
`default_nettype wire

// File: rtl/ttc_broadcast_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : ttc_broadcast_transmitter
// Brief    : Queues TTC broadcast requests and issues them as rate-limited
//            Brcst byte strobes in fixed priority order.
// Revision : 1.0 - initial release
// ============================================================================
module ttc_broadcast_transmitter #(
  parameter int GAP = 44
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  ttc_broadcast_transmitter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STROBE = 2'd1,
    S_GAP    = 2'd2
  } state_t;

  localparam logic [7:0] c_CODE_BCNT  = 8'h01;
  localparam logic [7:0] c_CODE_EVT   = 8'h02;
  localparam logic [7:0] c_CODE_TS    = 8'h28;
  localparam logic [7:0] c_CODE_START = 8'hC0;
  localparam logic [7:0] c_CODE_STOP  = 8'h80;
  localparam logic [7:0] c_GAP_LAST   = 8'(GAP - 2);

  state_t      state_q, state_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic [7:0]  brcst_q, brcst_d;
  logic        brcst_str_q, brcst_str_d;
  logic [31:0] sent_q, sent_d;
  logic [31:0] dropped_q, dropped_d;
  logic [2:0]  simple_p_q, simple_p_d;   // [0]=bcnt [1]=evt [2]=ts
  logic        start_p_q, start_p_d;
  logic        stop_p_q, stop_p_d;
  logic        fill_p_q, fill_p_d;
  logic [4:0]  fill_type_q, fill_type_d;

  logic [2:0]  w_req_s;
  logic [2:0]  w_f_s, w_r_s;
  logic        w_new_start, w_new_stop;
  logic        w_fill_valid;
  logic        w_async_p;
  logic        w_can_issue;
  logic [4:0]  w_sel;
  logic [2:0]  w_drops;
  logic        w_f_start, w_f_stop, w_r_start, w_r_stop;
  logic        w_f_fill, w_r_fill;

  assign w_req_s = {bus.req_ts_reset, bus.req_evt_reset, bus.req_bcnt_reset};

  always_comb begin
    state_d     = state_q;
    gap_cnt_d   = gap_cnt_q;
    brcst_d     = brcst_q;
    brcst_str_d = 1'b0;
    sent_d      = sent_q;
    fill_type_d = fill_type_q;
    w_drops     = 3'd0;
    w_sel       = 5'b0;

    w_new_start  = bus.req_async_start & ~bus.req_async_stop;
    w_new_stop   = bus.req_async_stop;
    w_fill_valid = bus.req_fill_type & (|bus.fill_type_in);
    w_async_p    = start_p_q | stop_p_q;

    // Issue decisions may also be taken on the final GAP cycle so that a
    // backlog drains with strobes exactly GAP cycles apart.
    w_can_issue = bus.tx_enable &
                  ((state_q == S_IDLE) || (state_q == S_GAP && gap_cnt_q == 8'd0));

    if (simple_p_q[0] | w_req_s[0])              w_sel[0] = 1'b1;
    else if (simple_p_q[1] | w_req_s[1])         w_sel[1] = 1'b1;
    else if (simple_p_q[2] | w_req_s[2])         w_sel[2] = 1'b1;
    else if (w_async_p | bus.req_async_start | bus.req_async_stop)
                                                 w_sel[3] = 1'b1;
    else if (fill_p_q | w_fill_valid)            w_sel[4] = 1'b1;
    if (!w_can_issue) w_sel = 5'b0;

    case (state_q)
      S_IDLE: if (|w_sel) state_d = S_STROBE;
      S_STROBE: begin
        state_d   = S_GAP;
        gap_cnt_d = c_GAP_LAST;
      end
      S_GAP: begin
        if (gap_cnt_q == 8'd0) state_d = (|w_sel) ? S_STROBE : S_IDLE;
        else                   gap_cnt_d = gap_cnt_q - 8'd1;
      end
      default: state_d = S_IDLE;
    endcase

    if (|w_sel) begin
      brcst_str_d = 1'b1;
      sent_d      = sent_q + 32'd1;
      if (w_sel[0])      brcst_d = c_CODE_BCNT;
      else if (w_sel[1]) brcst_d = c_CODE_EVT;
      else if (w_sel[2]) brcst_d = c_CODE_TS;
      else if (w_sel[3]) brcst_d = start_p_q ? c_CODE_START :
                                   stop_p_q  ? c_CODE_STOP  :
                                   w_new_stop ? c_CODE_STOP : c_CODE_START;
      else               brcst_d = {(fill_p_q ? fill_type_q : bus.fill_type_in), 3'b100};
    end

    // An issued type consumes its pending flag if set, otherwise the
    // incoming request; whatever remains of both is merged below.
    w_f_s = simple_p_q & ~(w_sel[2:0] & simple_p_q);
    w_r_s = w_req_s    & ~(w_sel[2:0] & ~simple_p_q);
    simple_p_d = w_f_s | w_r_s;
    for (int i = 0; i < 3; i++)
      if (w_f_s[i] & w_r_s[i]) w_drops = w_drops + 3'd1;

    w_f_start = start_p_q & ~(w_sel[3] & w_async_p);
    w_f_stop  = stop_p_q  & ~(w_sel[3] & w_async_p);
    w_r_start = w_new_start & ~(w_sel[3] & ~w_async_p);
    w_r_stop  = w_new_stop  & ~(w_sel[3] & ~w_async_p);
    start_p_d = w_r_start | (w_f_start & ~w_r_stop);
    stop_p_d  = w_r_stop  | (w_f_stop  & ~w_r_start);
    if (bus.req_async_start & bus.req_async_stop) w_drops = w_drops + 3'd1;
    if ((w_r_start | w_r_stop) & (w_f_start | w_f_stop)) w_drops = w_drops + 3'd1;

    w_f_fill = fill_p_q     & ~(w_sel[4] & fill_p_q);
    w_r_fill = w_fill_valid & ~(w_sel[4] & ~fill_p_q);
    fill_p_d = w_f_fill | w_r_fill;
    if (w_r_fill) fill_type_d = bus.fill_type_in;
    if (w_f_fill & w_r_fill) w_drops = w_drops + 3'd1;
    if (bus.req_fill_type & ~(|bus.fill_type_in)) w_drops = w_drops + 3'd1;

    dropped_d = dropped_q + {29'd0, w_drops};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      gap_cnt_q   <= 8'd0;
      brcst_q     <= 8'h00;
      brcst_str_q <= 1'b0;
      sent_q      <= 32'd0;
      dropped_q   <= 32'd0;
      simple_p_q  <= 3'b000;
      start_p_q   <= 1'b0;
      stop_p_q    <= 1'b0;
      fill_p_q    <= 1'b0;
      fill_type_q <= 5'b00001;
    end else begin
      state_q     <= state_d;
      gap_cnt_q   <= gap_cnt_d;
      brcst_q     <= brcst_d;
      brcst_str_q <= brcst_str_d;
      sent_q      <= sent_d;
      dropped_q   <= dropped_d;
      simple_p_q  <= simple_p_d;
      start_p_q   <= start_p_d;
      stop_p_q    <= stop_p_d;
      fill_p_q    <= fill_p_d;
      fill_type_q <= fill_type_d;
    end
  end

  assign bus.brcst         = brcst_q;
  assign bus.brcst_str     = brcst_str_q;
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.sent_count    = sent_q;
  assign bus.dropped_count = dropped_q;

endmodule
`default_nettype wire

// File: tb/tb_ttc_broadcast_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ttc_broadcast_transmitter
// Brief    : Directed and random stimulus against a slot/time-based model of
//            the broadcast transmitter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ttc_broadcast_transmitter;
  localparam int GAP = 8;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  ttc_broadcast_transmitter_if bus ();

  ttc_broadcast_transmitter #(.GAP(GAP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: one slot per request kind (async start/stop share a slot), and a
  // strobe may appear in cycle n only when n - last_str >= GAP.
  bit          mpend [5];
  logic [7:0]  mcode [5];
  int          last_str;
  int          mcyc;
  logic [7:0]  e_brcst;
  logic        e_str;
  logic [31:0] e_sent;
  logic [31:0] e_drop;
  logic        e_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, mcyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      mpend[i] = 1'b0;
      mcode[i] = 8'h00;
    end
    last_str = -1000;
    mcyc     = 0;
    e_brcst  = 8'h00;
    e_str    = 1'b0;
    e_sent   = 0;
    e_drop   = 0;
    e_busy   = 1'b0;
  endtask

  task automatic model_step(input bit en, input bit b, input bit e, input bit t,
                            input bit as, input bit ap, input bit rf, input logic [4:0] ft);
    bit         inc [5];
    logic [7:0] icode [5];
    int         issue;
    inc[0] = b;  icode[0] = 8'h01;
    inc[1] = e;  icode[1] = 8'h02;
    inc[2] = t;  icode[2] = 8'h28;
    inc[3] = as | ap;  icode[3] = ap ? 8'h80 : 8'hC0;
    if (as && ap) e_drop++;
    inc[4] = 1'b0;  icode[4] = {ft, 3'b100};
    if (rf) begin
      if (ft == 5'd0) e_drop++;
      else inc[4] = 1'b1;
    end
    issue = -1;
    if (en && (mcyc + 1 - last_str >= GAP))
      for (int i = 4; i >= 0; i--)
        if (mpend[i] || inc[i]) issue = i;
    e_str = 1'b0;
    if (issue >= 0) begin
      e_str = 1'b1;
      e_sent++;
      last_str = mcyc + 1;
      if (mpend[issue]) begin
        e_brcst = mcode[issue];
        mpend[issue] = 1'b0;
      end else begin
        e_brcst = icode[issue];
        inc[issue] = 1'b0;
      end
    end
    for (int i = 0; i < 5; i++)
      if (inc[i]) begin
        if (mpend[i]) e_drop++;
        mpend[i] = 1'b1;
        mcode[i] = icode[i];
      end
    mcyc++;
    e_busy = (mcyc - last_str) < GAP;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".str"},   {31'd0, bus.brcst_str}, {31'd0, e_str});
    chk({tag, ".brcst"}, {24'd0, bus.brcst},     {24'd0, e_brcst});
    chk({tag, ".busy"},  {31'd0, bus.busy},      {31'd0, e_busy});
    chk({tag, ".sent"},  bus.sent_count,         e_sent);
    chk({tag, ".drop"},  bus.dropped_count,      e_drop);
  endtask

  task automatic step(input bit en, input bit b, input bit e, input bit t,
                      input bit as, input bit ap, input bit rf, input logic [4:0] ft,
                      input string tag);
    bus.tx_enable       = en;
    bus.req_bcnt_reset  = b;
    bus.req_evt_reset   = e;
    bus.req_ts_reset    = t;
    bus.req_async_start = as;
    bus.req_async_stop  = ap;
    bus.req_fill_type   = rf;
    bus.fill_type_in    = ft;
    model_step(en, b, e, t, as, ap, rf, ft);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input int n, input bit en, input string tag);
    for (int i = 0; i < n; i++) step(en, 0, 0, 0, 0, 0, 0, 5'd0, tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.tx_enable = 1'b1;
    bus.req_bcnt_reset = 1'b0;  bus.req_evt_reset = 1'b0;  bus.req_ts_reset = 1'b0;
    bus.req_async_start = 1'b0; bus.req_async_stop = 1'b0; bus.req_fill_type = 1'b0;
    bus.fill_type_in = 5'd0;
    model_reset();
    #2;
    do_reset();
    check_all("reset");

    // Single ts reset: strobe next cycle with 8'h28, busy for GAP cycles
    step(1, 0, 0, 1, 0, 0, 0, 5'd0, "ts_req");
    chk("ts_code", {24'd0, bus.brcst}, 32'h28);
    idle(GAP + 2, 1, "ts_idle");

    // bcnt + evt + fill(3) together: 01, 02, 1C at GAP spacing
    step(1, 1, 1, 0, 0, 0, 1, 5'b00011, "prio3");
    idle(3 * GAP + 2, 1, "prio3_idle");

    // Fill overwrite while pending during a GAP
    step(1, 1, 0, 0, 0, 0, 0, 5'd0, "ovw_bcnt");
    step(1, 0, 0, 0, 0, 0, 1, 5'b00010, "ovw_f1");
    step(1, 0, 0, 0, 0, 0, 1, 5'b00111, "ovw_f2");
    idle(2 * GAP, 1, "ovw_idle");

    // Async start+stop same cycle, then rejected zero fill type
    step(1, 0, 0, 0, 1, 1, 0, 5'd0, "async_both");
    idle(GAP, 1, "async_idle");
    step(1, 0, 0, 0, 0, 0, 1, 5'd0, "fill_zero");
    idle(3, 1, "fz_idle");

    // Disabled queue, then drain in priority order
    step(0, 0, 0, 0, 0, 0, 1, 5'b00101, "dis_fill");
    step(0, 0, 0, 1, 0, 0, 0, 5'd0, "dis_ts");
    step(0, 1, 0, 0, 0, 0, 0, 5'd0, "dis_bcnt");
    idle(5, 0, "dis_idle");
    idle(3 * GAP + 2, 1, "en_drain");

    // Async reset in GAP cycle 5 with further work pending
    step(1, 0, 1, 0, 0, 0, 0, 5'd0, "rst_evt");
    step(1, 1, 0, 0, 1, 0, 0, 5'd0, "rst_gap1");
    idle(4, 1, "rst_gap");
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1, 0, 0, 0, 0, 1, 0, 5'd0, "post_rst");
    idle(GAP + 1, 1, "post_rst_idle");

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 9) != 0),
           ($urandom_range(0, 11) == 0), ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 11) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0),
           5'($urandom_range(0, 31)), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/ttc_broadcast_transmitter.md
TTC_BROADCAST_TRANSMITTER -- requirements
Module: ttc_broadcast_transmitter

Interface
REQ-001 Parameter GAP, default 44: minimum cycles from one brcst_str assertion to the next (legal range 2..255).
REQ-002 clk  input  1  single system clock; all logic on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 tx_enable  input  1  when low, requests still queue but no broadcast starts.
REQ-005 req_bcnt_reset  input  1  one-cycle pulse: request bunch count reset broadcast.
REQ-006 req_evt_reset  input  1  one-cycle pulse: request event count reset broadcast.
REQ-007 req_ts_reset  input  1  one-cycle pulse: request timestamp reset broadcast.
REQ-008 req_async_start  input  1  one-cycle pulse: request start of asynchronous pulse storage.
REQ-009 req_async_stop  input  1  one-cycle pulse: request stop of asynchronous pulse storage.
REQ-010 req_fill_type  input  1  one-cycle pulse: request fill type switch.
REQ-011 fill_type_in  input  5  fill type code, sampled with req_fill_type.
REQ-012 brcst  output  8  broadcast byte, Brcst[7:0]; decoder's chan_b_info = brcst[7:2].
REQ-013 brcst_str  output  1  one-cycle broadcast strobe.
REQ-014 busy  output  1  high while a broadcast strobe or its GAP interval is in progress.
REQ-015 sent_count  output  32  broadcasts issued since reset.
REQ-016 dropped_count  output  32  requests discarded or overwritten since reset.

Function
REQ-017 The block encodes: bcnt reset = 8'h01; evt reset = 8'h02; ts reset = 8'h28 (00101_0_00); async start = 8'hC0; async stop = 8'h80; fill type = {fill_type_in,3'b100}.
REQ-018 Each request type has a pending flag, set on the edge sampling its request pulse.
REQ-019 A request whose pending flag is already set (and not being issued that cycle) increments dropped_count by 1 and keeps a single pending entry.
REQ-020 Repeated req_fill_type while pending overwrites the stored fill type with the newest fill_type_in and increments dropped_count.
REQ-021 req_fill_type with fill_type_in == 0 is rejected: not queued, dropped_count +1.
REQ-022 req_async_start and req_async_stop are mutually exclusive: a new one cancels the other's pending flag (dropped_count +1); both in the same cycle -> stop wins, dropped_count +1.
REQ-023 Several request pulses in one cycle each set their own flag; dropped_count increments by the total number of drops in that cycle.
REQ-024 FSM states IDLE, STROBE, GAP.
REQ-025 IDLE -> STROBE when tx_enable=1 and any pending flag is set; a request pulse in IDLE produces brcst_str on the next cycle (latency 1).
REQ-026 Priority when several flags are pending: bcnt > evt > ts > async start/stop > fill type.
REQ-027 On entry to STROBE, brcst is loaded with the selected code, brcst_str=1 for exactly one cycle, the selected flag clears, and sent_count increments.
REQ-028 A new request of the type being issued in that same cycle becomes pending again and is not counted as dropped.
REQ-029 STROBE -> GAP; GAP lasts GAP-1 cycles, then -> IDLE, so consecutive strobes are exactly GAP cycles apart under backlog.
REQ-030 brcst holds its last value between strobes.
REQ-031 busy = 1 in STROBE and GAP, 0 in IDLE.
REQ-032 tx_enable going low mid-broadcast does not truncate STROBE or GAP; it only blocks the next IDLE->STROBE.
REQ-033 sent_count and dropped_count wrap from 32'hFFFFFFFF to 0.

Reset
REQ-034 When reset is asserted, the block asynchronously sets brcst=8'h00, brcst_str=0, busy=0, state=IDLE, both counters and all pending flags to 0, and stored fill type to 5'b00001.
REQ-035 Reset asserted mid-STROBE or mid-GAP aborts immediately; requests in the first cycle after release are accepted normally.

Verification
REQ-036 Verify: req_ts_reset at t, idle, enabled -> brcst_str at t+1 with brcst=8'h28; busy for GAP cycles; sent_count=1.
REQ-037 Verify: bcnt, evt, and fill(5'b00011) requested in the same cycle -> strobes 8'h01, 8'h02, 8'h1C, each exactly GAP cycles apart.
REQ-038 Verify: req_fill_type 5'b00010 then 5'b00111 during GAP -> single strobe 8'h3C; dropped_count=1.
REQ-039 Verify: async start and stop in the same cycle -> single strobe 8'h80; dropped_count=1; fill_type_in=0 request -> no strobe, dropped_count=2.
REQ-040 Verify: tx_enable=0 with 3 requests queued -> no strobes; after tx_enable=1 -> 3 strobes in priority order.
REQ-041 Verify: reset asserted in GAP cycle 5 -> outputs clear without waiting for a clock edge; pending work is lost; sent_count=0.
